// File: rtl/pong_ball_engine_if.sv
// rtl/pong_ball_engine_if.sv - pixel, paddle, ball and score signals of the Pong ball engine
interface pong_ball_engine_if #(
  parameter int COORD_W = 10,
  parameter int SCORE_W = 4
);
  logic               tick;
  logic               run;
  logic [COORD_W-1:0] x;
  logic [COORD_W-1:0] y;
  logic [COORD_W-1:0] xpad1;
  logic [COORD_W-1:0] ypad1;
  logic [COORD_W-1:0] xpad2;
  logic [COORD_W-1:0] ypad2;
  logic               ball_on;
  logic [11:0]        ball_colour;
  logic [COORD_W-1:0] xball;
  logic [COORD_W-1:0] yball;
  logic [SCORE_W-1:0] p1s;
  logic [SCORE_W-1:0] p2s;
  logic               point_p1;
  logic               point_p2;
  logic               game_over;
  logic [1:0]         state;

  modport master (
    output tick, run, x, y, xpad1, ypad1, xpad2, ypad2,
    input  ball_on, ball_colour, xball, yball, p1s, p2s,
           point_p1, point_p2, game_over, state
  );

  modport slave (
    input  tick, run, x, y, xpad1, ypad1, xpad2, ypad2,
    output ball_on, ball_colour, xball, yball, p1s, p2s,
           point_p1, point_p2, game_over, state
  );
endinterface

// File: rtl/pong_ball_engine.sv
// rtl/pong_ball_engine.sv - Pong ball motion, bounces, scoring and rally FSM; PONG_SPEEDUP_EN adds paddle-hit speedup
module pong_ball_engine #(
  parameter int COORD_W     = 10,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480,
  parameter int BALL_SIZE   = 24,
  parameter int PAD_W       = 12,
  parameter int PAD_H       = 80,
  parameter int SPEED_W     = 3,
  parameter int SPEED_INIT  = 1,
  parameter int SPEED_MAX   = 6,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_TICKS = 60
) (
  input  logic              clk,
  input  logic              reset,
  pong_ball_engine_if.slave bus
);
  localparam int W1    = COORD_W + 1;
  localparam int CNT_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [COORD_W-1:0] X_CENTRE   = COORD_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] Y_CENTRE   = COORD_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [COORD_W-1:0] BALL_C     = COORD_W'(BALL_SIZE);
  localparam logic [COORD_W-1:0] PADW_C     = COORD_W'(PAD_W);
  localparam logic [W1-1:0]      BALL_E     = W1'(BALL_SIZE);
  localparam logic [W1-1:0]      HRES_E     = W1'(H_RES);
  localparam logic [W1-1:0]      VRES_E     = W1'(V_RES);
  localparam logic [W1-1:0]      PADW_E     = W1'(PAD_W);
  localparam logic [W1-1:0]      PADH_E     = W1'(PAD_H);
  localparam logic [SCORE_W-1:0] WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [SCORE_W-1:0] ONE_S      = SCORE_W'(1);
  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_TICKS - 1);

  generate
    if (SPEED_MAX > (2 ** SPEED_W) - 1 || SPEED_INIT > SPEED_MAX) begin : g_bad_speed
      $error("pong_ball_engine: speed parameters do not fit SPEED_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    OVER  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COORD_W-1:0] xb_q, xb_d, yb_q, yb_d;
  logic               dx_right_q, dx_right_d;
  logic               dy_down_q, dy_down_d;
  logic [SCORE_W-1:0] p1s_q, p1s_d, p2s_q, p2s_d;
  logic               pt1_q, pt1_d, pt2_q, pt2_d;
  logic [SPEED_W-1:0] speed;

`ifdef PONG_SPEEDUP_EN
  logic [SPEED_W-1:0] speed_q, speed_d;
  assign speed = speed_q;
`else
  assign speed = SPEED_W'(SPEED_INIT);
`endif

  // Widened copies so every comparison is free of wrap-around.
  logic [W1-1:0] xb, yb, sp, xp1, yp1, xp2, yp2, face1, xb_far, yb_far;
  logic [COORD_W-1:0] sp_c;
  assign xb     = {1'b0, xb_q};
  assign yb     = {1'b0, yb_q};
  assign sp     = W1'(speed);
  assign sp_c   = COORD_W'(speed);
  assign xp1    = {1'b0, bus.xpad1};
  assign yp1    = {1'b0, bus.ypad1};
  assign xp2    = {1'b0, bus.xpad2};
  assign yp2    = {1'b0, bus.ypad2};
  assign face1  = xp1 + PADW_E;
  assign xb_far = xb + BALL_E;
  assign yb_far = yb + BALL_E;

  logic overlap1, overlap2, left_hit, right_hit, left_miss, right_miss;
  assign overlap1   = (yb_far > yp1) && (yb < yp1 + PADH_E);
  assign overlap2   = (yb_far > yp2) && (yb < yp2 + PADH_E);
  assign left_hit   = !dx_right_q && (xb >= face1) && (xb < face1 + sp) && overlap1;
  assign right_hit  = dx_right_q && (xb_far <= xp2) && (xb_far + sp > xp2) && overlap2;
  assign left_miss  = !dx_right_q && (xb <= sp);
  assign right_miss = dx_right_q && (xb_far + sp >= HRES_E);

  logic [COORD_W-1:0] y_next;
  logic               dy_next;
  always_comb begin
    y_next  = yb_q;
    dy_next = dy_down_q;
    if (!dy_down_q) begin
      if (yb <= sp) begin
        y_next  = '0;
        dy_next = 1'b1;
      end else begin
        y_next = yb_q - sp_c;
      end
    end else if (yb_far + sp >= VRES_E) begin
      y_next  = COORD_W'(V_RES - BALL_SIZE);
      dy_next = 1'b0;
    end else begin
      y_next = yb_q + sp_c;
    end
  end

  logic [SCORE_W-1:0] p1s_inc, p2s_inc;
  assign p1s_inc = p1s_q + ONE_S;
  assign p2s_inc = p2s_q + ONE_S;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    xb_d       = xb_q;
    yb_d       = yb_q;
    dx_right_d = dx_right_q;
    dy_down_d  = dy_down_q;
    p1s_d      = p1s_q;
    p2s_d      = p2s_q;
    pt1_d      = 1'b0;
    pt2_d      = 1'b0;
`ifdef PONG_SPEEDUP_EN
    speed_d    = speed_q;
`endif
    if (bus.tick && bus.run) begin
      unique case (state_q)
        SERVE: begin
          if (cnt_q == SERVE_LAST) begin
            state_d = PLAY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PLAY: begin
          yb_d      = y_next;
          dy_down_d = dy_next;
          if (left_hit || right_hit) begin
            xb_d       = left_hit ? (bus.xpad1 + PADW_C) : (bus.xpad2 - BALL_C);
            dx_right_d = left_hit;
`ifdef PONG_SPEEDUP_EN
            if (speed_q < SPEED_W'(SPEED_MAX)) speed_d = speed_q + SPEED_W'(1);
`endif
          end else if (left_miss || right_miss) begin
            // Ball restarts toward the player who conceded, on the other vertical heading.
            xb_d       = X_CENTRE;
            yb_d       = Y_CENTRE;
            dx_right_d = right_miss;
            dy_down_d  = !dy_down_q;
`ifdef PONG_SPEEDUP_EN
            speed_d    = SPEED_W'(SPEED_INIT);
`endif
            if (right_miss) begin
              pt1_d   = 1'b1;
              p1s_d   = p1s_inc;
              state_d = (p1s_inc == WIN_S) ? OVER : SERVE;
            end else begin
              pt2_d   = 1'b1;
              p2s_d   = p2s_inc;
              state_d = (p2s_inc == WIN_S) ? OVER : SERVE;
            end
          end else begin
            xb_d = dx_right_q ? (xb_q + sp_c) : (xb_q - sp_c);
          end
        end
        OVER: begin
        end
        default: state_d = SERVE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= SERVE;
      cnt_q      <= '0;
      xb_q       <= X_CENTRE;
      yb_q       <= Y_CENTRE;
      dx_right_q <= 1'b1;
      dy_down_q  <= 1'b0;
      p1s_q      <= '0;
      p2s_q      <= '0;
      pt1_q      <= 1'b0;
      pt2_q      <= 1'b0;
`ifdef PONG_SPEEDUP_EN
      speed_q    <= SPEED_W'(SPEED_INIT);
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      xb_q       <= xb_d;
      yb_q       <= yb_d;
      dx_right_q <= dx_right_d;
      dy_down_q  <= dy_down_d;
      p1s_q      <= p1s_d;
      p2s_q      <= p2s_d;
      pt1_q      <= pt1_d;
      pt2_q      <= pt2_d;
`ifdef PONG_SPEEDUP_EN
      speed_q    <= speed_d;
`endif
    end
  end

  logic [W1-1:0] px, py;
  assign px = {1'b0, bus.x};
  assign py = {1'b0, bus.y};

  assign bus.ball_on     = (px >= xb) && (px < xb_far) && (py >= yb) && (py < yb_far);
  assign bus.ball_colour = 12'hBBB;
  assign bus.xball       = xb_q;
  assign bus.yball       = yb_q;
  assign bus.p1s         = p1s_q;
  assign bus.p2s         = p2s_q;
  assign bus.point_p1    = pt1_q;
  assign bus.point_p2    = pt2_q;
  assign bus.game_over   = (state_q == OVER);
  assign bus.state       = state_q;
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb/tb_pong_ball_engine.sv - randomized scoreboard bench for pong_ball_engine
`timescale 1ns/1ps
module tb_pong_ball_engine;
  localparam int CW = 10, SW = 4, H = 640, V = 480, B = 24, PW = 12, PH = 80;
  localparam int SPW = 3, SP0 = 3, SPMAX = 6, WIN = 3, ST = 4;
  localparam int XC = (H - B) / 2, YC = (V - B) / 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pong_ball_engine_if #(.COORD_W(CW), .SCORE_W(SW)) bus ();

  pong_ball_engine #(
    .COORD_W(CW), .H_RES(H), .V_RES(V), .BALL_SIZE(B), .PAD_W(PW), .PAD_H(PH),
    .SPEED_W(SPW), .SPEED_INIT(SP0), .SPEED_MAX(SPMAX), .SCORE_W(SW),
    .WIN_SCORE(WIN), .SERVE_TICKS(ST)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    int xb; int yb; int s1; int s2; int st; int pt1; int pt2;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model: position, signed direction (+1 right/down, -1 left/up), speed, scores, phase.
  int mx, my, mdx, mdy, msp, ms1, ms2, mst, mcnt;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_expected(input int pt1, input int pt2);
    exp_t e;
    e.xb = mx; e.yb = my; e.s1 = ms1; e.s2 = ms2; e.st = mst; e.pt1 = pt1; e.pt2 = pt2;
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    mx = XC; my = YC; mdx = 1; mdy = -1; msp = SP0;
    ms1 = 0; ms2 = 0; mst = 0; mcnt = 0;
    push_expected(0, 0);
  endtask

  task automatic model_tick(input bit r, input int xp1, input int yp1, input int xp2, input int yp2);
    int nx, ny, ndy, face1, scorer;
    bit ov1, ov2;
    scorer = 0;
    if (r && mst == 0) begin
      if (mcnt == ST - 1) begin mst = 1; mcnt = 0; end
      else mcnt++;
    end else if (r && mst == 1) begin
      ny = my + mdy * msp;
      ndy = mdy;
      if (ny <= 0) begin ny = 0; ndy = 1; end
      else if (ny + B >= V) begin ny = V - B; ndy = -1; end
      ov1 = (my + B > yp1) && (my < yp1 + PH);
      ov2 = (my + B > yp2) && (my < yp2 + PH);
      face1 = xp1 + PW;
      nx = mx + mdx * msp;
      if (mdx < 0 && mx >= face1 && nx < face1 && ov1) begin
        nx = face1; mdx = 1;
`ifdef PONG_SPEEDUP_EN
        if (msp < SPMAX) msp++;
`endif
      end else if (mdx > 0 && mx + B <= xp2 && nx + B > xp2 && ov2) begin
        nx = xp2 - B; mdx = -1;
`ifdef PONG_SPEEDUP_EN
        if (msp < SPMAX) msp++;
`endif
      end else if (mdx < 0 && nx <= 0) scorer = 2;
      else if (mdx > 0 && nx + B >= H) scorer = 1;
      if (scorer != 0) begin
        if (scorer == 1) ms1++; else ms2++;
        mx = XC; my = YC; msp = SP0;
        mdx = (scorer == 2) ? -1 : 1;
        mdy = -mdy;
        mst = ((scorer == 1 ? ms1 : ms2) == WIN) ? 2 : 0;
      end else begin
        mx = nx; my = ny; mdy = ndy;
      end
    end
    push_expected(scorer == 1, scorer == 2);
  endtask

  task automatic issue_tick(input bit r, input int xp1, input int yp1, input int xp2, input int yp2);
    @(negedge clk);
    bus.run = r;
    bus.xpad1 = CW'(xp1); bus.ypad1 = CW'(yp1);
    bus.xpad2 = CW'(xp2); bus.ypad2 = CW'(yp2);
    bus.tick = 1'b1;
    model_tick(r, xp1, yp1, xp2, yp2);
    @(negedge clk);
    bus.tick = 1'b0;
  endtask

  task automatic do_reset(input bit with_tick);
    @(negedge clk);
    reset = 1'b1;
    bus.tick = with_tick;
    bus.run = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bus.tick = 1'b0;
  endtask

  function automatic int pick_pad();
    int p;
    if ($urandom_range(0, 1) == 1) p = my - PH + 1 + int'($urandom_range(0, PH + B - 2));
    else p = int'($urandom_range(0, V - PH));
    if (p < 0) p = 0;
    if (p > V - PH) p = V - PH;
    return p;
  endfunction

  task automatic probe_pixel(input int px, input int py);
    @(negedge clk);
    bus.x = CW'(px); bus.y = CW'(py);
    #1;
    check("ball_on", bus.ball_on, (px >= mx && px < mx + B && py >= my && py < my + B));
  endtask

  task automatic check_ball_on();
    probe_pixel(mx, my);
    probe_pixel(mx + B - 1, my + B - 1);
    probe_pixel(mx + B, my + B / 2);
    probe_pixel(mx + B / 2, my + B);
    if (mx > 0) probe_pixel(mx - 1, my);
    if (my > 0) probe_pixel(mx, my - 1);
    probe_pixel(int'($urandom_range(0, H - 1)), int'($urandom_range(0, V - 1)));
  endtask

  // Monitor: an expected record is due on the cycle after every tick or reset edge.
  logic tick_seen = 1'b0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    tick_seen <= bus.tick;
    rst_seen  <= reset;
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (tick_seen || rst_seen) begin
        if (exp_q.size() == 0) begin
          check("queue_underflow", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("xball", bus.xball, e.xb);
          check("yball", bus.yball, e.yb);
          check("p1s", bus.p1s, e.s1);
          check("p2s", bus.p2s, e.s2);
          check("state", bus.state, e.st);
          check("game_over", bus.game_over, (e.st == 2));
          check("point_p1", bus.point_p1, e.pt1);
          check("point_p2", bus.point_p2, e.pt2);
          check("ball_colour", bus.ball_colour, 12'hBBB);
        end
      end else begin
        check("point_idle", {bus.point_p1, bus.point_p2}, 0);
      end
    end
  end

  initial begin : stimulus
    int over_ticks;
    int yp1, yp2;
    bit r;
    reset = 1'b1;
    bus.tick = 1'b0; bus.run = 1'b0;
    bus.x = '0; bus.y = '0;
    bus.xpad1 = '0; bus.ypad1 = CW'(200);
    bus.xpad2 = CW'(H - PW); bus.ypad2 = CW'(200);
    model_reset();
    @(negedge clk);
    reset = 1'b0;

    // Serve hold, then the first move up and to the right.
    repeat (ST) issue_tick(1'b1, 0, 200, H - PW, 200);
    #1;
    check("serve_to_play", bus.state, 1);
    check("serve_hold_x", bus.xball, XC);
    issue_tick(1'b1, 0, 200, H - PW, 200);
    #1;
    check("first_move_x", bus.xball, XC + SP0);
    check("first_move_y", bus.yball, YC - SP0);
    check_ball_on();

    // Frozen game: ticks with run low change nothing.
    repeat (10) issue_tick(1'b0, 0, 200, H - PW, 200);
    #1;
    check("freeze_x", bus.xball, XC + SP0);

    over_ticks = 0;
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 99) < 85);
      yp1 = pick_pad();
      yp2 = pick_pad();
      issue_tick(r, int'($urandom_range(0, 16)), yp1, int'($urandom_range(600, H - PW)), yp2);
      repeat ($urandom_range(0, 1)) @(negedge clk);
      if (mst == 2) over_ticks++;
      if (over_ticks > 5 || $urandom_range(0, 499) == 0) begin
        do_reset(bit'($urandom_range(0, 1)));
        over_ticks = 0;
      end
      if (i % 64 == 0) check_ball_on();
    end

    repeat (4) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pong_ball_engine.md
# pong_ball_engine

Parametrised ball engine for the Pong datapath. It moves the ball one step per frame tick, bounces it off the top/bottom walls and both paddles, detects misses, and keeps both players' scores. A serve/play/game-over state machine runs the rally. The block sits between the paddle controllers and the VGA pixel mux, and drives `ball_on`/`ball_colour` for the current pixel.

## Interface
Parameters:
- `COORD_W`, 10: width of all coordinates.
- `H_RES`, 640: visible width in pixels.
- `V_RES`, 480: visible height in pixels.
- `BALL_SIZE`, 24: ball is a BALL_SIZE×BALL_SIZE square.
- `PAD_W`, 12: paddle width.
- `PAD_H`, 80: paddle height.
- `SPEED_W`, 3: width of the speed register.
- `SPEED_INIT`, 1: pixels per tick at serve.
- `SPEED_MAX`, 6: speed ceiling; must be ≤ 2^SPEED_W−1.
- `SCORE_W`, 4: width of each score.
- `WIN_SCORE`, 9: score that ends the game.
- `SERVE_TICKS`, 60: ticks the ball rests centred before each serve.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: one-cycle frame strobe; all motion advances only on tick.
- `run` in 1: game enable; low freezes all state.
- `x`, `y` in COORD_W: current pixel coordinate.
- `xpad1`, `ypad1` in COORD_W: top-left of left paddle (player 1).
- `xpad2`, `ypad2` in COORD_W: top-left of right paddle (player 2).
- `ball_on` out 1: current pixel lies inside the ball (combinational).
- `ball_colour` out 12: constant 12'hBBB.
- `xball`, `yball` out COORD_W: ball top-left, registered.
- `p1s`, `p2s` out SCORE_W: player scores, registered.
- `point_p1`, `point_p2` out 1: one-cycle pulse when the player scores.
- `game_over` out 1: high in OVER.
- `state` out 2: SERVE=0, PLAY=1, OVER=2.

## Operation
- Reset values:
  - xball=(H_RES−BALL_SIZE)/2, yball=(V_RES−BALL_SIZE)/2.
  - p1s=p2s=0, speed=SPEED_INIT.
  - dx=right, dy=up.
  - state=SERVE, serve counter=0.
  - point pulses=0, game_over=0.
- SERVE: ball held at centre; counter increments per tick. On the tick where counter==SERVE_TICKS−1, go to PLAY and clear the counter.
- PLAY, per tick, vertical move:
  - Moving up and yball ≤ speed: yball=0, dy=down.
  - Moving down and yball+BALL_SIZE+speed ≥ V_RES: yball=V_RES−BALL_SIZE, dy=up.
  - Otherwise yball ±= speed.
- Vertical overlap with paddle n means yball+BALL_SIZE > ypadn and yball < ypadn+PAD_H.
- Left hit: dx=left, xball ≥ xpad1+PAD_W, xball−speed < xpad1+PAD_W, and overlap with paddle 1. Result: xball=xpad1+PAD_W, dx=right.
- Right hit: dx=right, xball+BALL_SIZE ≤ xpad2, xball+BALL_SIZE+speed > xpad2, and overlap with paddle 2. Result: xball=xpad2−BALL_SIZE, dx=left.
- Left miss: no hit, dx=left, xball ≤ speed. Player 2 scores.
- Right miss: no hit, dx=right, xball+BALL_SIZE+speed ≥ H_RES. Player 1 scores.
- Otherwise xball ±= speed.
- A paddle hit takes priority over a miss. Vertical and horizontal updates apply on the same tick.
- On a point:
  - Pulse the scorer's point strobe and increment that score.
  - Re-centre the ball and set speed=SPEED_INIT.
  - dx points toward the player who conceded; dy toggles.
  - If the new score == WIN_SCORE go to OVER, else go to SERVE.
- OVER: ball centred, game_over=1. Stays in OVER until reset; tick is ignored.
- Arithmetic: all comparisons are done at COORD_W+1 bits so there is no wrap. Subtractions never go below 0 because of the clamp rules above.

## Timing
- Registered outputs update on the clk edge where tick=1 and run=1. Latency is 1 cycle from tick.
- tick with run=0 is ignored: position, counter and score are held.
- point_p1/point_p2 are high for exactly the one cycle in which the score changes.
- ball_on is combinational from x, y, xball, yball with zero latency. The condition is xball ≤ x < xball+BALL_SIZE and yball ≤ y < yball+BALL_SIZE.
- reset asserted mid-rally or in OVER wins over tick. All state is at reset values on the next cycle.
- tick pulses wider than one cycle are not supported. Each high cycle counts as one tick.

## Configuration
- `PONG_SPEEDUP_EN`:
  - Defined: each paddle hit increments speed by 1, saturating at SPEED_MAX. Speed returns to SPEED_INIT on every point.
  - Undefined: speed is constant SPEED_INIT, and the speed register and increment logic are removed.

## Test plan
- Reset, run=1, SERVE_TICKS=4: ball stays at (308,228) for 4 ticks, then state=PLAY. After one more tick xball=309, yball=227.
- Ball moving up at yball=1, speed=2, one tick: yball=0, dy=down. Next tick yball=2.
- ypad1=200, ball at yball=210 moving left, xball=14 (just right of the paddle face at 12), speed=3, xpad1=0: xball=12, dx=right. With PONG_SPEEDUP_EN, speed becomes 4.
- Same setup but ypad1=300: no hit. The following ticks reach xball ≤ speed, giving point_p2 pulse, p2s=1, ball re-centred, state=SERVE.
- WIN_SCORE=2 and two right misses: p1s=2, game_over=1, state=OVER. Further ticks change nothing; reset returns all outputs to reset values.
- Toggle run=0 for 10 ticks mid-rally: xball, yball, scores and state unchanged. Motion resumes on the first tick after run=1.
